// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl: accepts parallel words over a valid/ready handshake, buffers
// one word, and shifts it out MSB-first at DIV clocks per bit. A buffered word
// is loaded in the last clock of the previous word, so frames stream with no
// idle bit between them.
module piso_tx_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             sdo,
  output logic             sen,
  output logic             bit_tick,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] BIT_ONE  = CW'(1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [WIDTH-1:0] sr_r;
  logic [WIDTH-1:0] sr_nxt_s;
  logic [CW-1:0]    bit_cnt_r;
  logic [CW-1:0]    bit_cnt_nxt_s;
  logic [DW-1:0]    div_cnt_r;
  logic [DW-1:0]    div_cnt_nxt_s;
  logic             hold_valid_r;
  logic             hold_valid_nxt_s;
  logic [WIDTH-1:0] hold_data_r;

  logic             handshake_s;
  logic             load_s;
  logic             in_shift_s;
  logic             div_last_s;
  logic             bit_last_s;

  assign in_shift_s  = (state_r == ST_SHIFT);
  assign div_last_s  = (div_cnt_r == DIV_LAST);
  assign bit_last_s  = (bit_cnt_r == BIT_LAST);
  // A handshake needs an empty buffer and a load needs a full one, so the two
  // can never coincide.
  assign handshake_s = s_valid & ~hold_valid_r;

  // Sequencer: load from the holding register, divide the clock, shift bits.
  always_comb begin
    state_nxt_s   = state_r;
    sr_nxt_s      = sr_r;
    bit_cnt_nxt_s = bit_cnt_r;
    div_cnt_nxt_s = div_cnt_r;
    load_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (hold_valid_r) begin
          load_s        = 1'b1;
          state_nxt_s   = ST_SHIFT;
          sr_nxt_s      = hold_data_r;
          bit_cnt_nxt_s = '0;
          div_cnt_nxt_s = '0;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (div_last_s) begin
          div_cnt_nxt_s = '0;
          if (!bit_last_s) begin
            sr_nxt_s      = {sr_r[WIDTH-2:0], 1'b0};
            bit_cnt_nxt_s = bit_cnt_r + BIT_ONE;
          end else if (hold_valid_r) begin
            // Next word follows on the very next clock: no gap bit.
            load_s        = 1'b1;
            state_nxt_s   = ST_SHIFT;
            sr_nxt_s      = hold_data_r;
            bit_cnt_nxt_s = '0;
          end else begin
            state_nxt_s   = ST_IDLE;
            sr_nxt_s      = '0;
            bit_cnt_nxt_s = '0;
          end
        end else begin
          div_cnt_nxt_s = div_cnt_r + DIV_ONE;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        sr_nxt_s      = '0;
        bit_cnt_nxt_s = '0;
        div_cnt_nxt_s = '0;
      end
    endcase
  end

  // Holding-register occupancy: set by a handshake, cleared by a load.
  always_comb begin
    if (handshake_s) begin
      hold_valid_nxt_s = 1'b1;
    end else if (load_s) begin
      hold_valid_nxt_s = 1'b0;
    end else begin
      hold_valid_nxt_s = hold_valid_r;
    end
  end

  // Sequencer state registers; reset discards the frame and the buffered word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      sr_r         <= '0;
      bit_cnt_r    <= '0;
      div_cnt_r    <= '0;
      hold_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      sr_r         <= sr_nxt_s;
      bit_cnt_r    <= bit_cnt_nxt_s;
      div_cnt_r    <= div_cnt_nxt_s;
      hold_valid_r <= hold_valid_nxt_s;
    end
  end

  // Holding data captures the source word on a handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_data_r <= '0;
    end else if (handshake_s) begin
      hold_data_r <= s_data;
    end else begin
      hold_data_r <= hold_data_r;
    end
  end

  // Outputs decode registered state only, so they drop at once on reset.
  assign s_ready  = ~hold_valid_r;
  assign sen      = in_shift_s;
  assign sdo      = in_shift_s & sr_r[WIDTH-1];
  assign bit_tick = in_shift_s & div_last_s;
  assign done     = in_shift_s & div_last_s & bit_last_s;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl: a WIDTH=8/DIV=4 instance and a WIDTH=4/DIV=1
// instance, both checked every cycle against a word/time-slot reference model.
module tb_piso_tx_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       va, vb;
  logic [7:0] da;
  logic [3:0] db;
  logic       a_ready, a_sdo, a_sen, a_tick, a_done;
  logic       b_ready, b_sdo, b_sen, b_tick, b_done;

  piso_tx_ctrl #(.WIDTH(8), .DIV(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .s_valid(va), .s_data(da), .s_ready(a_ready),
    .sdo(a_sdo), .sen(a_sen), .bit_tick(a_tick), .done(a_done)
  );

  piso_tx_ctrl #(.WIDTH(4), .DIV(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .s_valid(vb), .s_data(db), .s_ready(b_ready),
    .sdo(b_sdo), .sen(b_sen), .bit_tick(b_tick), .done(b_done)
  );

  always #5 clk = ~clk;

  // Reference model: an active word plus a time slot t in 0..W*D-1, and a
  // one-entry holding buffer.
  int         mw [2] = '{8, 4};
  int         md [2] = '{4, 1};
  logic       m_act [2];
  int         m_t [2];
  logic [7:0] m_word [2];
  logic       m_hv [2];
  logic [7:0] m_hd [2];

  int    n_checks = 0;
  int    n_errors = 0;
  string phase = "reset";
  int    cyc;
  int    sen_cnt, sen_first, sen_last, done_cnt, done_first, done_last;
  int    b_sen_cnt, b_tick_cnt, b_done_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic e_sdo(input int i);
    if (!m_act[i]) return 1'b0;
    return m_word[i][mw[i] - 1 - m_t[i] / md[i]];
  endfunction

  function automatic logic e_tick(input int i);
    return m_act[i] && ((m_t[i] % md[i]) == md[i] - 1);
  endfunction

  function automatic logic e_done(input int i);
    return m_act[i] && (m_t[i] == mw[i] * md[i] - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_t[i] = 0; m_hv[i] = 1'b0; m_word[i] = 8'h00; m_hd[i] = 8'h00;
    end
  endtask

  task automatic model_edge(input int i, input logic v, input logic [7:0] d);
    logic hs;
    hs = v && !m_hv[i];
    if (m_act[i]) begin
      if (m_t[i] == mw[i] * md[i] - 1) begin
        if (m_hv[i]) begin
          m_word[i] = m_hd[i]; m_hv[i] = 1'b0; m_t[i] = 0;
        end else begin
          m_act[i] = 1'b0; m_t[i] = 0;
        end
      end else begin
        m_t[i]++;
      end
    end else if (m_hv[i]) begin
      m_act[i] = 1'b1; m_word[i] = m_hd[i]; m_hv[i] = 1'b0; m_t[i] = 0;
    end
    if (hs) begin
      m_hv[i] = 1'b1; m_hd[i] = d;
    end
  endtask

  task automatic check_all();
    chk("a_ready", 32'(a_ready), 32'(!m_hv[0]));
    chk("a_sdo",   32'(a_sdo),   32'(e_sdo(0)));
    chk("a_sen",   32'(a_sen),   32'(m_act[0]));
    chk("a_tick",  32'(a_tick),  32'(e_tick(0)));
    chk("a_done",  32'(a_done),  32'(e_done(0)));
    chk("b_ready", 32'(b_ready), 32'(!m_hv[1]));
    chk("b_sdo",   32'(b_sdo),   32'(e_sdo(1)));
    chk("b_sen",   32'(b_sen),   32'(m_act[1]));
    chk("b_tick",  32'(b_tick),  32'(e_tick(1)));
    chk("b_done",  32'(b_done),  32'(e_done(1)));
  endtask

  task automatic reset_stats();
    cyc = -1;
    sen_cnt = 0; sen_first = -1; sen_last = -1;
    done_cnt = 0; done_first = -1; done_last = -1;
    b_sen_cnt = 0; b_tick_cnt = 0; b_done_first = -1;
  endtask

  // One clock: check outputs, advance the model at the edge, then record
  // the new cycle's outputs at the falling edge.
  task automatic step();
    check_all();
    @(posedge clk);
    model_edge(0, va, da);
    model_edge(1, vb, {4'b0000, db});
    cyc++;
    @(negedge clk);
    if (a_sen) begin
      sen_cnt++;
      if (sen_first < 0) sen_first = cyc;
      sen_last = cyc;
    end
    if (a_done) begin
      done_cnt++;
      if (done_first < 0) done_first = cyc;
      done_last = cyc;
    end
    if (b_sen) b_sen_cnt++;
    if (b_tick) b_tick_cnt++;
    if (b_done && b_done_first < 0) b_done_first = cyc;
  endtask

  logic [7:0] bp_words [3] = '{8'h5A, 8'hC3, 8'h96};
  int         hs_cyc [3];
  int         idx;
  logic       hs_now;

  initial begin
    // Reset with random inputs on both instances.
    reset_n = 1'b1; va = 1'b0; vb = 1'b0; da = 8'h00; db = 4'h0;
    model_reset();
    #1 reset_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      va = 1'($urandom); vb = 1'($urandom); da = 8'($urandom); db = 4'($urandom);
      #1 check_all();
    end
    va = 1'b0; vb = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    phase = "idle";
    reset_stats();
    repeat (4) step();

    // Single word on each instance: A5 at DIV=4, 1001 at DIV=1.
    phase = "single";
    reset_stats();
    va = 1'b1; da = 8'hA5; vb = 1'b1; db = 4'b1001;
    step();
    va = 1'b0; vb = 1'b0;
    repeat (40) step();
    chk("sen_cnt", 32'(sen_cnt), 32'd32);
    chk("sen_first", 32'(sen_first), 32'd1);
    chk("done_cnt", 32'(done_cnt), 32'd1);
    chk("done_cyc", 32'(done_first), 32'd32);
    chk("b_sen_cnt", 32'(b_sen_cnt), 32'd4);
    chk("b_tick_cnt", 32'(b_tick_cnt), 32'd4);
    chk("b_done_cyc", 32'(b_done_first), 32'd4);

    // Back-to-back: A5 at cycle 0, 3C at cycle 2.
    phase = "b2b";
    reset_stats();
    va = 1'b1; da = 8'hA5; step();
    va = 1'b0; step();
    va = 1'b1; da = 8'h3C; step();
    va = 1'b0;
    repeat (70) step();
    chk("sen_cnt", 32'(sen_cnt), 32'd64);
    chk("sen_first", 32'(sen_first), 32'd1);
    chk("sen_last", 32'(sen_last), 32'd64);
    chk("done_cnt", 32'(done_cnt), 32'd2);
    chk("done_first", 32'(done_first), 32'd32);
    chk("done_last", 32'(done_last), 32'd64);

    // Backpressure: s_valid held high with three words queued.
    phase = "bp";
    reset_stats();
    idx = 0;
    va = 1'b1;
    for (int k = 0; k < 150 && idx < 3; k++) begin
      da = bp_words[idx];
      hs_now = a_ready;
      step();
      if (hs_now) begin
        hs_cyc[idx] = cyc;
        idx++;
      end
    end
    va = 1'b0;
    chk("hs_count", 32'(idx), 32'd3);
    if (idx == 3) begin
      chk("hs0_cyc", 32'(hs_cyc[0]), 32'd0);
      chk("hs1_cyc", 32'(hs_cyc[1]), 32'd2);
      chk("hs2_cyc", 32'(hs_cyc[2]), 32'd34);
    end
    repeat (110) step();
    chk("sen_cnt", 32'(sen_cnt), 32'd96);
    chk("done_cnt", 32'(done_cnt), 32'd3);

    // Reset mid-frame while sending FF with 81 buffered.
    phase = "midreset";
    reset_stats();
    va = 1'b1; da = 8'hFF; step();
    va = 1'b0; step();
    va = 1'b1; da = 8'h81; step();
    va = 1'b0;
    repeat (8) step();
    chk("sen_before", 32'(a_sen), 32'd1);
    chk("sdo_before", 32'(a_sdo), 32'd1);
    chk("ready_before", 32'(a_ready), 32'd0);
    reset_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
    reset_stats();
    repeat (12) step();
    chk("sen_after", 32'(sen_cnt), 32'd0);

    // Random traffic on both instances.
    phase = "rand";
    reset_stats();
    repeat (600) begin
      va = ($urandom_range(0, 3) != 0);
      vb = ($urandom_range(0, 2) == 0);
      da = 8'($urandom);
      db = 4'($urandom);
      step();
    end
    va = 1'b0; vb = 1'b0;
    repeat (80) step();
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
